// File: rtl/imem_loader.sv
// imem_loader: packs a host byte stream little-endian into 32-bit words and writes them into the instruction region.
// Define IMEM_LOADER_CHECKSUM_EN to add a running mod-2^32 checksum of written words.
module imem_loader #(
    parameter int ADDR_W = 64,
    parameter logic [ADDR_W-1:0] IM_BASE = ADDR_W'(2048),
    parameter logic [ADDR_W-1:0] IM_LIMIT = ADDR_W'(6144),
    parameter int CNT_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [5:0]        wr_row,
    output logic [5:0]        wr_col,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              trap,
    output logic [CNT_W-1:0]  word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, TRAP} state_t;
    state_t state;
    logic [1:0] byte_idx;
    logic [31:0] word, word_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic last_seen, bad_base;
    assign bad_base = |base_addr[1:0] || base_addr < IM_BASE || base_addr >= IM_LIMIT;
    assign byte_ready = state == COLLECT;
    assign busy = state == COLLECT || state == WRITE;
    assign wr_row = wr_addr[13:8];
    assign wr_col = wr_addr[7:2];
    always_comb word_nxt = word | ({24'b0, byte_data} << {byte_idx, 3'b000});
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            byte_idx <= '0;
            word <= '0;
            cur_addr <= '0;
            last_seen <= 1'b0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done <= 1'b0;
            trap <= 1'b0;
            word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, TRAP: if (start) begin
                    done <= 1'b0;
                    if (bad_base) begin
                        state <= TRAP;
                        trap <= 1'b1;
                    end else begin
                        state <= COLLECT;
                        trap <= 1'b0;
                        cur_addr <= base_addr;
                        word_count <= '0;
                        byte_idx <= '0;
                        word <= '0;
                        last_seen <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                COLLECT: if (byte_valid) begin
                    word <= word_nxt;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3 || byte_last) begin
                        state <= WRITE;
                        wr_en <= 1'b1;
                        wr_addr <= cur_addr;
                        wr_data <= word_nxt;
                        last_seen <= byte_last;
                    end
                end
                WRITE: begin
                    wr_en <= 1'b0;
                    cur_addr <= cur_addr + ADDR_W'(4);
                    word_count <= word_count + CNT_W'(1);
                    byte_idx <= '0;
                    word <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    checksum <= checksum + wr_data;
`endif
                    // A stream that has not ended but has no room left for another word overflows the region
                    if (last_seen) begin
                        state <= DONE;
                        done <= 1'b1;
                    end else if (cur_addr + ADDR_W'(4) >= IM_LIMIT) begin
                        state <= TRAP;
                        trap <= 1'b1;
                    end else begin
                        state <= COLLECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized loads of imem_loader checked against a byte-list reference model.
module tb_imem_loader;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, byte_valid = 1'b0, byte_last = 1'b0;
    logic [63:0] base_addr = '0;
    logic [7:0] byte_data = '0;
    logic byte_ready, wr_en, busy, done, trap;
    logic [63:0] wr_addr;
    logic [5:0] wr_row, wr_col;
    logic [31:0] wr_data;
    logic [10:0] word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif
    int vectors = 0, miscompares = 0, wr_total = 0;
    logic [7:0] pb[$];

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .busy(busy), .done(done), .trap(trap),
        .word_count(word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (wr_en) wr_total++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word w of the program: bytes 4w..4w+3 little-endian, missing bytes are zero
    function automatic logic [31:0] pack(input int w);
        logic [31:0] v = '0;
        for (int k = 0; k < 4; k++) if (4 * w + k < pb.size()) v[8*k +: 8] = pb[4*w+k];
        return v;
    endfunction

    task automatic load(input logic [63:0] base, input bit last, input int gap, input bit poke);
        int n = pb.size(), k = 0, w = 0, idle = 0, wr0, cap, total, exp_w, exp_k;
        bit fin = 0, skip = 0, acc, wl, exp_trap;
        logic [63:0] a;
        logic [31:0] exp_sum = '0;
        cap = int'((64'd6144 - base) >> 2);
        total = last ? (n + 3) / 4 : n / 4;
        exp_w = total < cap ? total : cap;
        exp_trap = cap < total;
        exp_k = n < 4 * exp_w ? n : 4 * exp_w;
        wr0 = wr_total;
        @(negedge clk); start = 1'b1; base_addr = base;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (!fin && idle < 40) begin
            if (!skip) @(negedge clk);
            skip = 0;
            start = poke && k == 1;
            if (poke) base_addr = 64'd2050;
            byte_valid = k < n && $urandom_range(99) >= gap;
            byte_data = k < n ? pb[k] : 8'($urandom);
            byte_last = last && k == n - 1;
            acc = byte_valid && byte_ready;
            wl = acc && (k % 4 == 3 || byte_last);
            if (acc) begin k++; idle = 0; end else idle++;
            if (wl) begin
                a = base + 64'(4 * w);
                @(negedge clk);
                start = 1'b0;
                byte_valid = k < n;
                byte_data = k < n ? pb[k] : 8'h00;
                byte_last = last && k == n - 1;
                chk("wr_en", wr_en, 1);
                chk("wr_addr", wr_addr, a);
                chk("wr_row", wr_row, a[13:8]);
                chk("wr_col", wr_col, a[7:2]);
                chk("wr_data", wr_data, pack(w));
                chk("ready_in_write", byte_ready, 0);
                exp_sum += pack(w);
                w++;
                fin = (last && k == n) || a + 64'd4 >= 64'd6144;
                @(negedge clk);
                chk("ready_after_write", byte_ready, !fin);
                skip = 1;
            end
        end
        start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("load_finished", fin, 1);
        chk("bytes_accepted", k, exp_k);
        chk("writes", wr_total - wr0, exp_w);
        chk("word_count", word_count, exp_w);
        chk("done", done, !exp_trap);
        chk("trap", trap, exp_trap);
        chk("busy_end", busy, 0);
        chk("ready_end", byte_ready, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!exp_trap) chk("checksum", checksum, exp_sum);
`endif
    endtask

    task automatic bad_start(input logic [63:0] base);
        int wr0 = wr_total;
        @(negedge clk); start = 1'b1; base_addr = base;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("bad_trap", trap, 1);
        chk("bad_ready", byte_ready, 0);
        chk("bad_done", done, 0);
        byte_valid = 1'b1; byte_data = 8'h5A;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        chk("bad_writes", wr_total - wr0, 0);
        chk("bad_busy", busy, 0);
        chk("bad_trap_held", trap, 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wr0;
        repeat (2) @(negedge clk);
        chk("rst_ready", byte_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_trap", trap, 0);
        chk("rst_count", word_count, 0);
        reset = 1'b0;
        pb = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load(64'd2048, 1, 0, 0);
        pb = {8'hAA, 8'hBB};
        load(64'd4096, 1, 0, 0);
        bad_start(64'd2050);
        bad_start(64'd6144);
        bad_start(64'd2044);
        pb = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load(64'd6140, 0, 0, 0);
        pb = {};
        for (int i = 0; i < 16; i++) pb.push_back(8'($urandom));
        load(64'd6128, 1, 30, 0);
        pb = {};
        for (int i = 0; i < 9; i++) pb.push_back(8'($urandom));
        load(64'd3000, 1, 20, 1);
        for (int r = 0; r < 8; r++) begin
            pb = {};
            for (int i = 0; i < int'($urandom_range(1, 40)); i++) pb.push_back(8'($urandom));
            load(r % 2 ? 64'd6144 - 64'(4 * $urandom_range(1, 16)) : 64'd2048 + 64'(4 * $urandom_range(0, 900)), 1, 40, 0);
        end
        // Reset in the middle of a word: partial bytes must be dropped without a write
        wr0 = wr_total;
        @(negedge clk); start = 1'b1; base_addr = 64'd2048;
        @(negedge clk); start = 1'b0; byte_valid = 1'b1; byte_data = 8'h11;
        @(negedge clk); byte_data = 8'h22;
        @(negedge clk); byte_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ready", byte_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_trap", trap, 0);
        chk("mid_rst_count", word_count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_writes", wr_total - wr0, 0);
        pb = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load(64'd2048, 1, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Accepts a byte stream from a host or boot source and packs it little-endian into 32-bit words.
- Issues one-cycle word writes into the instruction region [2048, 6144) of main memory, which the fetch side later reads by pc.
- Enforces the same region bounds as the fetch side and raises a trap on violation.

Parameters:
- ADDR_W, 64, width of base/write addresses (matches pc width)
- IM_BASE, 2048, first legal instruction byte address (inclusive)
- IM_LIMIT, 6144, end of instruction region (exclusive)
- CNT_W, 11, width of word_count (max 1024 words)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a load; sampled only in IDLE, DONE or TRAP
- base_addr  in  ADDR_W  byte address of first word; sampled with start
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  stream byte
- byte_last  in  1  qualifies byte_valid; final byte of program
- byte_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  ADDR_W  byte address of the word being written
- wr_row  out  6  memory row = wr_addr[13:8]
- wr_col  out  6  memory column = wr_addr[7:2]
- wr_data  out  32  packed instruction word
- busy  out  1  high in COLLECT or WRITE
- done  out  1  load completed; held
- trap  out  1  bounds/alignment violation; held
- word_count  out  CNT_W  words written in the current load

Behaviour:
- Reset (async): state IDLE; all outputs 0; partial word, byte index and current address cleared. A mid-load reset discards the partial word, and no write is issued.
- FSM states: IDLE, COLLECT, WRITE, DONE, TRAP.
- IDLE/DONE/TRAP, start=1:
  - base_addr[1:0]!=0, base_addr<IM_BASE or base_addr>=IM_LIMIT: go to TRAP next cycle.
  - Otherwise latch cur_addr=base_addr, clear word_count, done, trap and the 2-bit byte_idx, then go to COLLECT.
- start while busy is ignored.
- COLLECT:
  - byte_ready=1.
  - Accept when byte_valid&&byte_ready; the byte goes to bits [8*byte_idx+7 : 8*byte_idx]; byte_idx increments.
  - Go to WRITE on the cycle after the 4th byte or a byte_last byte is accepted.
  - Bytes not received before byte_last are zero-padded.
- WRITE:
  - byte_ready=0; wr_en=1 for exactly one cycle, with wr_addr=cur_addr and row/col derived from it.
  - Next cycle: cur_addr+=4, word_count+=1, byte_idx=0, partial word cleared.
  - If byte_last was seen, go to DONE.
  - Else if cur_addr+4>=IM_LIMIT, go to TRAP (stream overflows the region).
  - Else return to COLLECT.
- Latency: 4th byte accepted in cycle N → wr_en in N+1 → byte_ready high again in N+2. Peak throughput is 4 bytes per 5 cycles.
- DONE: done=1 held, busy=0, wr_en=0, until start or reset.
- TRAP: trap=1 held, byte_ready=0, no further writes, until start or reset. A `$display("trap ")` message is allowed in simulation only.
- Exact fill: a program ending on the last word (addr 6140) with byte_last goes to DONE, not TRAP.
- byte_valid while byte_ready=0 is ignored; the source must hold the byte.
- wr_data/wr_addr hold their last value when wr_en=0.
- word_count never wraps: the maximum is 1024 words.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- When defined: add output checksum[31:0]. It is cleared on reset and on accepted start, and each written word's wr_data is added mod 2^32 in the WRITE cycle. The value is valid and held in DONE.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Aligned 8-byte load: base=2048, bytes 13 00 00 00 93 00 10 00, last on 8th byte. Expect writes of 0x00000013 @2048 (row 8, col 0) and 0x00100093 @2052; done=1, word_count=2, trap=0.
- Partial last word: base=4096, bytes AA BB with last on BB. Expect a single write of 0x0000BBAA @4096, then done=1.
- Bad base: start with base=2050, then with base=6144. Expect trap=1 two cycles after start, no wr_en, byte_ready=0.
- Region overflow: base=6140, 8 bytes with no last after the 4th byte. Expect one write @6140, then trap=1, and byte_ready never reasserts.
- Backpressure and timing: present bytes continuously and check byte_ready drops for exactly the WRITE cycle. With byte_valid gapped randomly, data must be unchanged and wr_en must occur in cycle N+1 after the 4th accepted byte.
- Reset mid-load: assert reset after 2 of 4 bytes. Expect all outputs 0 immediately and no wr_en. A new start with base=2048 and 4 bytes then writes correctly; with the checksum macro defined, checksum equals that single word.
